// File: rtl/mem_readback_crc_pkg.sv
// Shared constants and types for the memory readback CRC block.
// Contents: CRC-32 (reflected) constants and the sweep state enum.
package mem_rb_pkg;

   localparam logic [31:0] CRC_POLY_REFL = 32'hEDB8_8320;
   localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
   localparam logic [31:0] CRC_XOROUT    = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2
   } rb_state_t;

endpackage

// File: rtl/mem_readback_crc_if.sv
// Simple-dual-port BRAM wrapper port bundle.
// master (sweeper): drives raddr, waddr, din; receives registered mem_dout.
// slave  (memory) : the opposite directions.
interface mem_readback_crc_if #(
   parameter int unsigned WID = 18,
   parameter int unsigned AW  = 12
);
   logic [AW-1:0]  raddr;
   logic [AW-1:0]  waddr;
   logic [WID-1:0] din;
   logic [WID-1:0] mem_dout;

   modport master (output raddr, output waddr, output din, input mem_dout);
   modport slave  (input raddr, input waddr, input din, output mem_dout);
endinterface

// File: rtl/mem_readback_crc_crc32_word.sv
// Combinational CRC-32 (reflected) update of one WID-bit word, LSB first.
// Ports: acc_in (running remainder), word (data), acc_out (updated remainder).
module crc32_word
   import mem_rb_pkg::*;
#(
   parameter int unsigned WID = 18
) (
   input  logic [31:0]    acc_in,
   input  logic [WID-1:0] word,
   output logic [31:0]    acc_out
);

   // Bit-serial shift register, unrolled WID times.
   always_comb begin
      logic [31:0] c;
      c = acc_in;
      for (int i = 0; i < int'(WID); i++) begin
         if (c[0] ^ word[i]) c = (c >> 1) ^ CRC_POLY_REFL;
         else                c = c >> 1;
      end
      acc_out = c;
   end

endmodule

// File: rtl/mem_readback_crc.sv
// Sweeps the whole BRAM once per start and produces a CRC-32 signature,
// writing every word back to where it was read so contents never change.
// Ports: clk, reset (sync, active-high), start (pulse), mem (BRAM bundle,
// master side), busy, done (pulse), crc (last completed signature).
// Optional macro MEM_RB_COMPARE_EN adds exp_crc (sampled on start) and pass.
module mem_readback_crc
   import mem_rb_pkg::*;
#(
   parameter int unsigned WID_MEM   = 18,
   parameter int unsigned DEPTH_MEM = 4096,
   parameter int unsigned ADDR_W    = 12
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   mem_readback_crc_if.master mem,
`ifdef MEM_RB_COMPARE_EN
   input  logic [31:0]        exp_crc,
   output logic               pass,
`endif
   output logic               busy,
   output logic               done,
   output logic [31:0]        crc
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH_MEM - 1);
   localparam logic [ADDR_W:0]   N_WORDS   = (ADDR_W + 1)'(DEPTH_MEM);

   rb_state_t         state_q, state_d;
   logic [ADDR_W-1:0] raddr_q, raddr_d;
   logic [ADDR_W-1:0] waddr_q;
   logic [ADDR_W:0]   rd_cnt_q, rd_cnt_d;
   logic [31:0]       acc_q, acc_d, acc_next;
   logic [31:0]       crc_d;
   logic              busy_d, done_d, fold;
`ifdef MEM_RB_COMPARE_EN
   logic [31:0]       exp_q, exp_d;
   logic              pass_d;
`endif

   crc32_word #(.WID(WID_MEM)) u_crc (
      .acc_in  (acc_q),
      .word    (mem.mem_dout),
      .acc_out (acc_next)
   );

   // Read-port word goes straight back to the address it was read from.
   assign mem.raddr = raddr_q;
   assign mem.waddr = waddr_q;
   assign mem.din   = mem.mem_dout;

   // Next-state and next-output logic.
   always_comb begin
      state_d  = state_q;
      raddr_d  = raddr_q;
      rd_cnt_d = rd_cnt_q;
      acc_d    = acc_q;
      crc_d    = crc;
      busy_d   = busy;
      done_d   = 1'b0;
      fold     = 1'b0;
`ifdef MEM_RB_COMPARE_EN
      exp_d    = exp_q;
      pass_d   = pass;
`endif
      case (state_q)
         IDLE: begin
            raddr_d = '0;
            if (start) begin
               state_d  = READ;
               busy_d   = 1'b1;
               acc_d    = CRC_INIT;
               rd_cnt_d = '0;
`ifdef MEM_RB_COMPARE_EN
               exp_d    = exp_crc;
`endif
            end
         end
         READ: begin
            raddr_d = raddr_q + ADDR_W'(1);
            // First READ cycle still shows the idle read of ram[0]; skip it.
            fold    = (raddr_q != '0);
            if (raddr_q == LAST_ADDR) state_d = DRAIN;
         end
         DRAIN: begin
            raddr_d = '0;
            fold    = 1'b1;
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            crc_d   = acc_next ^ CRC_XOROUT;
`ifdef MEM_RB_COMPARE_EN
            pass_d  = ((acc_next ^ CRC_XOROUT) == exp_q);
`endif
         end
         default: begin
            state_d = IDLE;
            raddr_d = '0;
            busy_d  = 1'b0;
         end
      endcase
      if (fold) begin
         acc_d    = acc_next;
         rd_cnt_d = rd_cnt_q + (ADDR_W + 1)'(1);
      end
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         raddr_q  <= '0;
         rd_cnt_q <= '0;
         acc_q    <= CRC_INIT;
         crc      <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
`ifdef MEM_RB_COMPARE_EN
         exp_q    <= '0;
         pass     <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         raddr_q  <= raddr_d;
         rd_cnt_q <= rd_cnt_d;
         acc_q    <= acc_d;
         crc      <= crc_d;
         busy     <= busy_d;
         done     <= done_d;
`ifdef MEM_RB_COMPARE_EN
         exp_q    <= exp_d;
         pass     <= pass_d;
`endif
      end
   end

   // Write address tracks read address even in reset so write-back stays paired.
   always_ff @(posedge clk) begin
      waddr_q <= raddr_q;
   end

   // The final fold must bring the count to exactly DEPTH_MEM words.
   always_ff @(posedge clk) begin
      if (!reset && state_q == DRAIN) begin
         assert (rd_cnt_q + (ADDR_W + 1)'(1) == N_WORDS);
      end
   end

endmodule

// File: tb/tb_mem_readback_crc.sv
// Bench for mem_readback_crc: a 4-word and a 4096-word instance, each with a
// behavioural BRAM, checked against a bit-stream CRC reference model.
module tb_mem_readback_crc;

   localparam int unsigned W  = 18;
   localparam int unsigned DS = 4;
   localparam int unsigned AS = 2;
   localparam int unsigned DB = 4096;
   localparam int unsigned AB = 12;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   logic start_s = 1'b0, start_b = 1'b0;
   logic busy_s, done_s, busy_b, done_b;
   logic [31:0] crc_s, crc_b;
`ifdef MEM_RB_COMPARE_EN
   logic [31:0] exp_s = '0, exp_b = '0;
   logic        pass_s, pass_b;
   logic        exp_pass_g = 1'b0;
`endif

   always #5 clk = ~clk;

   mem_readback_crc_if #(.WID(W), .AW(AS)) if_s ();
   mem_readback_crc_if #(.WID(W), .AW(AB)) if_b ();

   mem_readback_crc #(.WID_MEM(W), .DEPTH_MEM(DS), .ADDR_W(AS)) u_small (
      .clk(clk), .reset(reset), .start(start_s), .mem(if_s),
`ifdef MEM_RB_COMPARE_EN
      .exp_crc(exp_s), .pass(pass_s),
`endif
      .busy(busy_s), .done(done_s), .crc(crc_s)
   );

   mem_readback_crc #(.WID_MEM(W), .DEPTH_MEM(DB), .ADDR_W(AB)) u_big (
      .clk(clk), .reset(reset), .start(start_b), .mem(if_b),
`ifdef MEM_RB_COMPARE_EN
      .exp_crc(exp_b), .pass(pass_b),
`endif
      .busy(busy_b), .done(done_b), .crc(crc_b)
   );

   // Behavioural BRAMs: unconditional write, registered read, bench load port.
   logic [W-1:0]  ram_s [DS];
   logic [W-1:0]  ram_b [DB];
   logic          ld_s = 1'b0, ld_b = 1'b0;
   logic [AB-1:0] ld_addr = '0;
   logic [W-1:0]  ld_data = '0;

   always @(posedge clk) begin
      if (ld_s) ram_s[ld_addr[AS-1:0]] <= ld_data;
      else      ram_s[if_s.waddr]      <= if_s.din;
      if_s.mem_dout <= ram_s[if_s.raddr];
   end

   always @(posedge clk) begin
      if (ld_b) ram_b[ld_addr] <= ld_data;
      else      ram_b[if_b.waddr] <= if_b.din;
      if_b.mem_dout <= ram_b[if_b.raddr];
   end

   logic [W-1:0] img_s [$];
   logic [W-1:0] img_b [$];
   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Reference: message = all words LSB first; MSB-first CRC with the normal
   // polynomial, then bit-reverse the register (equivalent reflected CRC-32).
   function automatic logic [31:0] crc_ref(input logic [W-1:0] w [$]);
      bit          s [$];
      logic [31:0] c, r;
      logic        top;
      foreach (w[i]) for (int b = 0; b < int'(W); b++) s.push_back(w[i][b]);
      c = 32'hFFFF_FFFF;
      foreach (s[j]) begin
         top = c[31] ^ s[j];
         c   = {c[30:0], 1'b0};
         if (top) c = c ^ 32'h04C1_1DB7;
      end
      for (int i = 0; i < 32; i++) r[i] = c[31-i];
      return r ^ 32'hFFFF_FFFF;
   endfunction

   function automatic logic sel_busy(input bit big);
      return big ? busy_b : busy_s;
   endfunction
   function automatic logic sel_done(input bit big);
      return big ? done_b : done_s;
   endfunction
   function automatic logic [31:0] sel_crc(input bit big);
      return big ? crc_b : crc_s;
   endfunction

   task automatic set_start(input bit big, input logic v);
      if (big) start_b = v;
      else     start_s = v;
   endtask

   // Loads an image through the bench port while the DUTs sit in reset.
   task automatic load(input bit big, input logic [W-1:0] img [$]);
      reset = 1'b1;
      @(negedge clk);
      foreach (img[i]) begin
         ld_s    = !big;
         ld_b    = big;
         ld_addr = AB'(i);
         ld_data = img[i];
         @(negedge clk);
      end
      ld_s = 1'b0;
      ld_b = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic chk_ram(input bit big, input string tag);
      int bad = 0;
      if (big) begin
         foreach (img_b[i]) if (ram_b[i] !== img_b[i]) bad++;
      end else begin
         foreach (img_s[i]) if (ram_s[i] !== img_s[i]) bad++;
      end
      chk(tag, bad, 0);
   endtask

   // One sweep (optionally a second start at sample extra_k) observed for
   // horizon cycles; checks latency, busy length, done count and CRC.
   task automatic sweep(input bit big, input int extra_k, input int horizon,
                        input int exp_nd, input logic [31:0] golden, input string tag);
      int d      = big ? int'(DB) : int'(DS);
      int first  = -1;
      int second = -1;
      int nd     = 0;
      int nb     = 0;
      logic [31:0] crc_old = '0;
      logic [31:0] crc_first = '0;
      set_start(big, 1'b1);
      @(negedge clk);
      for (int k = 1; k <= horizon; k++) begin
         if (k == 1) crc_old = sel_crc(big);
         if (k == d + 1) chk({tag, " crc_hold"}, sel_crc(big), crc_old);
         if (sel_busy(big)) nb++;
         if (sel_done(big)) begin
            nd++;
            if (first < 0) begin
               first     = k;
               crc_first = sel_crc(big);
`ifdef MEM_RB_COMPARE_EN
               chk({tag, " pass"}, 32'(big ? pass_b : pass_s), 32'(exp_pass_g));
`endif
            end else if (second < 0) begin
               second = k;
            end
         end
         set_start(big, k == extra_k);
         @(negedge clk);
      end
      set_start(big, 1'b0);
      chk({tag, " ndone"}, nd, exp_nd);
      chk({tag, " done_at"}, first, d + 2);
      chk({tag, " busy_cycles"}, nb, exp_nd * (d + 1));
      chk({tag, " crc_at_done"}, crc_first, golden);
      chk({tag, " crc_end"}, sel_crc(big), golden);
      if (exp_nd == 2) chk({tag, " done_gap"}, second - first, d + 2);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end

   initial begin
      logic [31:0] g_s, g_b;
      int          n;
      int          nd;

      img_s = '{18'h000AA, 18'h00055, 18'h3FFFF, 18'h00000};
      for (int i = 0; i < int'(DB); i++) img_b.push_back(18'h000AA);
      load(1'b0, img_s);
      load(1'b1, img_b);

      chk("rst busy_s", 32'(busy_s), 0);
      chk("rst done_s", 32'(done_s), 0);
      chk("rst crc_s", crc_s, 0);
      chk("rst raddr_s", 32'(if_s.raddr), 0);
      chk("rst waddr_b", 32'(if_b.waddr), 0);
      chk("rst crc_b", crc_b, 0);

      g_s = crc_ref(img_s);
      g_b = crc_ref(img_b);

      sweep(1'b0, 0, DS + 6, 1, g_s, "small");
      chk_ram(1'b0, "small ram");
      sweep(1'b1, 0, DB + 6, 1, g_b, "big");
      chk_ram(1'b1, "big ram");
      sweep(1'b1, 2, DB + 6, 1, g_b, "dbl_start");

      // Reset abort in the middle of a sweep.
      start_b = 1'b1;
      @(negedge clk);
      start_b = 1'b0;
      n = 0;
      while (if_b.raddr !== 12'h200 && n < 5000) begin
         @(negedge clk);
         n++;
      end
      chk("abort reach_200", 32'(n < 5000), 1);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      chk("abort busy", 32'(busy_b), 0);
      chk("abort crc", crc_b, 0);
      nd = 0;
      for (int k = 0; k < int'(DB) + 4; k++) begin
         if (done_b) nd++;
         @(negedge clk);
      end
      chk("abort no_done", nd, 0);
      chk_ram(1'b1, "abort ram");
      sweep(1'b1, 0, DB + 6, 1, g_b, "after_abort");

      sweep(1'b0, DS + 2, 2 * DS + 6, 2, g_s, "b2b_s");
      sweep(1'b1, DB + 2, 2 * DB + 6, 2, g_b, "b2b_b");
      chk_ram(1'b1, "b2b ram");

      // Random small-RAM contents with random idle gaps.
      for (int t = 0; t < 4; t++) begin
         img_s.delete();
         for (int i = 0; i < int'(DS); i++) img_s.push_back(W'($urandom));
         load(1'b0, img_s);
         repeat ($urandom_range(0, 5)) @(negedge clk);
         g_s = crc_ref(img_s);
         sweep(1'b0, 0, DS + 6, 1, g_s, $sformatf("rand%0d", t));
         chk_ram(1'b0, $sformatf("rand%0d ram", t));
      end

`ifdef MEM_RB_COMPARE_EN
      exp_s      = g_s;
      exp_pass_g = 1'b1;
      sweep(1'b0, 0, DS + 6, 1, g_s, "cmp_match");
      exp_s      = g_s ^ 32'h1;
      exp_pass_g = 1'b0;
      sweep(1'b0, 0, DS + 6, 1, g_s, "cmp_miss");
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
